conv_window_ctrl: RTL
=====================

Name: conv_window_ctrl

Overview:
Sequencer for a chain of KSIZE-1 row buffers plus the KSIZE x KSIZE window registers that feed a convolution layer. It accepts a raster pixel stream through a valid/ready handshake and generates the shift enable for every row buffer and window register. It tracks row and column position and flags each position where a complete, in-image window is present, using a valid/ready output handshake. The block sits between the input image source and the conv PE array; one instance runs per conv layer.

Parameters:
COLS, 28, image width in pixels; also the row buffer depth.
ROWS, 28, image height in pixels.
KSIZE, 5, convolution kernel edge length; 2 <= KSIZE <= min(ROWS, COLS).
CNT_W, 5, counter width; 2^CNT_W >= max(ROWS, COLS).

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin one frame; sampled only in IDLE
in_valid  input  1  upstream pixel valid
in_ready  output  1  block can accept a pixel this cycle
rb_en  output  1  shift enable to all row buffers and window registers
win_valid  output  1  full window present at row buffer/window outputs
win_ready  input  1  downstream consumes window
win_row  output  CNT_W  output-map row of current window (0..ROWS-KSIZE)
win_col  output  CNT_W  output-map column of current window (0..COLS-KSIZE)
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset, applied in any state including mid-frame: state=IDLE. Counters row=0 and col=0. in_ready=0, win_valid=0, win_row=0, win_col=0, busy=0, frame_done=0. Row buffer contents are not cleared; stale data is never flagged valid.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN. Counters are cleared on entry.
- RUN: in_ready = !win_valid | win_ready. A pixel is accepted when in_valid & in_ready.
- rb_en = in_valid & in_ready, combinational, so the datapath shifts on the same edge the pixel is accepted. rb_en=0 in every state except RUN.
- On accept: col increments. At col=COLS-1, col wraps to 0 and row increments.
- Window flag: when the accepted pixel has row >= KSIZE-1 and col >= KSIZE-1:
  - win_valid is set on the next edge (1-cycle latency);
  - win_row=row-(KSIZE-1) and win_col=col-(KSIZE-1) are registered on that same edge.
- win_valid stays high, and win_row/win_col stay stable, until the edge where win_ready=1.
- Simultaneous consume and new window in the same cycle: win_valid stays 1 and the fields are updated. There is no bubble.
- Pixels in the first KSIZE-1 rows and the first KSIZE-1 columns of each row shift in with no window flagged. This covers the fill phase and the per-row wrap-around.
- Backpressure: while win_valid=1 and win_ready=0, in_ready=0, so the datapath is frozen and the window data remains aligned.
- Accept of the pixel at (ROWS-1, COLS-1) -> DRAIN. in_ready=0 from the next cycle.
- DRAIN: wait until win_valid=0, or until win_valid & win_ready this cycle, then -> DONE.
- DONE: frame_done=1 for exactly one cycle, then -> IDLE.
- start while busy is ignored. in_valid outside RUN is ignored and does not shift.
- Window count per frame: (ROWS-KSIZE+1)*(COLS-KSIZE+1), which is 576 for the defaults.
- Counters saturate nowhere. Row never exceeds ROWS-1 because the state leaves RUN on the last pixel.

Test Plan:
1. Defaults; start pulse, then 784 pixels with in_valid=1 and win_ready=1 -> rb_en high 784 cycles.
   - 576 win_valid windows in raster order.
   - First window (0,0) appears the cycle after pixel #117 (row 4, col 4).
   - Last window (23,23) appears the cycle after pixel #784.
   - Single-cycle frame_done follows, then busy=0.
2. Row wrap: observe pixels at row 5, col 0..3 -> no win_valid. Pixel (5,4) -> window (1,0) on the next cycle. No window is ever flagged with win_col>23.
3. Backpressure: hold win_ready=0 for 10 cycles on window (3,7) -> in_ready=0 and rb_en=0 for those cycles, win_row=3 and win_col=7 stable. Release -> window (3,8) next; total still 576.
4. Random in_valid gaps (about 30% idle) with win_ready=1 -> window sequence and count identical to test 1. rb_en is never high when in_valid=0.
5. Reset asserted during RUN at pixel #300 -> next cycle state IDLE, all outputs 0. A new start plus 784 pixels -> 576 correct windows with no stale window flagged.
6. start pulsed during RUN and during DRAIN -> ignored, with no counter disturbance. Also in_valid=1 while IDLE -> rb_en=0 and in_ready=0.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequences a raster pixel stream into KSIZE-1 row buffers
// and the KSIZE x KSIZE window registers. It also flags every output-map position
// where a complete, in-image window sits at the window register outputs.
module conv_window_ctrl #(
    parameter int COLS  = 28,
    parameter int ROWS  = 28,
    parameter int KSIZE = 5,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             rb_en,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] K_OFF    = CNT_W'(KSIZE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] row, col;
    logic             accept;
    logic             win_pos;
    logic             last_pix;

    // The pixel being accepted completes a window only once KSIZE-1 rows and
    // columns have already been shifted in ahead of it.
    assign win_pos  = (row >= K_OFF) && (col >= K_OFF);
    assign last_pix = (row == LAST_ROW) && (col == LAST_COL);

    // The datapath shifts on the same edge that accepts the pixel. in_ready is
    // low outside RUN, so nothing shifts in any other state.
    assign rb_en  = in_valid & in_ready;
    assign accept = rb_en;

    // Next-state and handshake decode. In RUN the block accepts input only when
    // the window slot is free or is being emptied this cycle.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                in_ready = !win_valid || win_ready;
                if (in_valid && in_ready && last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!win_valid || win_ready) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Raster position of the next pixel. It holds at the last pixel, so row
    // never passes ROWS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
        end else if (accept && !last_pix) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Window flag and coordinates, one cycle after the completing pixel.
    // When a new window arrives as the old one is consumed, the flag stays set
    // and the coordinates are replaced, so the output stream has no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (accept && win_pos) begin
            win_valid <= 1'b1;
            win_row   <= row - K_OFF;
            win_col   <= col - K_OFF;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule
